// File: rtl/histogram_reader.sv
// histogram_reader: sweeps the histogram RAM bins 0..LAST_BIN through its single
// synchronous port. Each (bin, count) pair goes out on a valid/ready stream. In
// clear mode, each bin is written to zero after it is read. The peak bin of the
// sweep is tracked and held until the next sweep starts.
module histogram_reader #(
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 7,
    parameter int LAST_BIN = 127
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic              clear_after_read,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] out_bin,
    output logic [DATA_W-1:0] out_count,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] peak_bin,
    output logic [DATA_W-1:0] peak_count
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        LAT,
        OUT,
        CLR,
        DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LAST_BIN);

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic              clr_mode;
    logic              at_last;
    logic [ADDR_W-1:0] addr_next;

    // Clear data is constant: the only write this block ever issues is a zero.
    assign mem_wdata = '0;

    // Advance-step helpers: the last-bin test is made before incrementing, so the address never wraps.
    always_comb begin
        at_last   = (addr == LAST_ADDR);
        addr_next = addr + ADDR_W'(1);
    end

    // Sweep sequencer; every output is registered and changes only on a state transition.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state      <= IDLE;
            addr       <= '0;
            clr_mode   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            mem_addr   <= '0;
            mem_wren   <= 1'b0;
            out_bin    <= '0;
            out_count  <= '0;
            out_valid  <= 1'b0;
            peak_bin   <= '0;
            peak_count <= '0;
        end else begin
            done     <= 1'b0;
            mem_wren <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        clr_mode   <= clear_after_read;
                        addr       <= '0;
                        mem_addr   <= '0;
                        peak_bin   <= '0;
                        peak_count <= '0;
                        busy       <= 1'b1;
                        state      <= RD;
                    end
                end
                RD: begin
                    // mem_addr already holds addr; the RAM returns the data next cycle.
                    state <= LAT;
                end
                LAT: begin
                    out_bin   <= addr;
                    out_count <= mem_rdata;
                    out_valid <= 1'b1;
                    // A strict compare lets the lowest bin win ties.
                    if (mem_rdata > peak_count) begin
                        peak_bin   <= addr;
                        peak_count <= mem_rdata;
                    end
                    state <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (clr_mode) begin
                            mem_wren <= 1'b1;
                            state    <= CLR;
                        end else if (at_last) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            addr     <= addr_next;
                            mem_addr <= addr_next;
                            state    <= RD;
                        end
                    end
                end
                CLR: begin
                    // The write was issued on entry; from here, advance as if clear mode were off.
                    if (at_last) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        addr     <= addr_next;
                        mem_addr <= addr_next;
                        state    <= RD;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_histogram_reader.sv
// Testbench for histogram_reader: a behavioural synchronous RAM, a scoreboard of
// expected (bin, count, cycle) words, and scenario tasks run in sequence.
module tb_histogram_reader;

    logic       CLK;
    logic       RST;
    logic       start;
    logic       clear_after_read;
    logic       busy;
    logic       done;
    logic [6:0] mem_addr;
    logic [6:0] mem_wdata;
    logic       mem_wren;
    logic [6:0] mem_rdata;
    logic [6:0] out_bin;
    logic [6:0] out_count;
    logic       out_valid;
    logic       out_ready;
    logic [6:0] peak_bin;
    logic [6:0] peak_count;

    histogram_reader #(
        .ADDR_W  (7),
        .DATA_W  (7),
        .LAST_BIN(127)
    ) dut (
        .CLK             (CLK),
        .RST             (RST),
        .start           (start),
        .clear_after_read(clear_after_read),
        .busy            (busy),
        .done            (done),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_wren        (mem_wren),
        .mem_rdata       (mem_rdata),
        .out_bin         (out_bin),
        .out_count       (out_count),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .peak_bin        (peak_bin),
        .peak_count      (peak_count)
    );

    typedef struct {
        logic [6:0] bin;
        logic [6:0] cnt;
        int         cyc;
    } exp_t;

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    exp_t       sbq[$];
    int         done_rel;
    int         done_cnt;
    int         wren_cnt;
    logic [6:0] img[128];
    logic [6:0] ram[128];
    bit         do_load = 1'b0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Single-port synchronous RAM: read data is available the cycle after the address.
    always @(posedge CLK) begin
        if (do_load) begin
            for (int i = 0; i < 128; i++) ram[i] <= img[i];
        end else if (mem_wren) begin
            ram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr];
    end

    task automatic load_ram();
        @(posedge CLK);
        #1;
        do_load = 1'b1;
        @(posedge CLK);
        #1;
        do_load = 1'b0;
    endtask

    // Expected words for one sweep: period p, and a shift of stall_len applied from bin stall_bin on.
    task automatic push_exp(input int p, input int stall_bin, input int stall_len);
        exp_t e;
        for (int i = 0; i < 128; i++) begin
            e.bin = 7'(i);
            e.cnt = img[i];
            e.cyc = 3 + p * i + ((i >= stall_bin) ? stall_len : 0);
            sbq.push_back(e);
        end
    endtask

    task automatic model_peak(output logic [6:0] pb, output logic [6:0] pc);
        pb = '0;
        pc = '0;
        for (int i = 0; i < 128; i++) begin
            if (img[i] > pc) begin
                pb = 7'(i);
                pc = img[i];
            end
        end
    endtask

    task automatic begin_sweep(input bit clr, output int t0);
        @(posedge CLK);
        #1;
        start            = 1'b1;
        clear_after_read = clr;
        t0               = cyc;
        @(posedge CLK);
        #1;
        start            = 1'b0;
        clear_after_read = ~clr;
    endtask

    // Runs one sweep from cycle 1; a parameter of 0 disables the stall, abort, or restart.
    task automatic sweep(input int t0, input int stall_from, input int stall_len,
                         input int abort_rel, input int restart_rel, input int limit);
        int   rel;
        int   hs_rel;
        int   lastb;
        bit   fin;
        bit   exp_busy;
        exp_t e;
        rel      = 1;
        hs_rel   = -10;
        lastb    = -1;
        fin      = 1'b0;
        done_rel = -1;
        done_cnt = 0;
        wren_cnt = 0;
        while (!fin) begin
            out_ready = !(rel >= stall_from && rel < stall_from + stall_len) && (rel != abort_rel);
            RST = (rel == abort_rel) ? 1'b0 : 1'b1;
            start = (rel == restart_rel);
            clear_after_read = (rel == restart_rel);
            @(negedge CLK);
            if (cyc - t0 != rel) begin
                total++; bad++;
                $display("FAIL cycle_align actual=%0d required=%0d", cyc - t0, rel);
            end
            if (abort_rel > 0 && rel == abort_rel + 1) begin
                total++;
                if ({out_valid, busy, mem_wren, done, out_bin, out_count, peak_bin, peak_count, mem_addr} !== '0) begin
                    bad++;
                    $display("FAIL abort_reset valid=%b busy=%b wren=%b done=%b bin=%0d cnt=%0d pb=%0d pc=%0d addr=%0d required all zero",
                             out_valid, busy, mem_wren, done, out_bin, out_count, peak_bin, peak_count, mem_addr);
                end
                fin = 1'b1;
            end else begin
                if (out_valid && out_ready) begin
                    total++;
                    if (sbq.size() == 0) begin
                        bad++;
                        $display("FAIL extra_word actual bin=%0d cnt=%0d rel=%0d required none", out_bin, out_count, rel);
                    end else begin
                        e = sbq.pop_front();
                        if (out_bin !== e.bin || out_count !== e.cnt || rel != e.cyc) begin
                            bad++;
                            $display("FAIL word actual bin=%0d cnt=%0d cyc=%0d required bin=%0d cnt=%0d cyc=%0d",
                                     out_bin, out_count, rel, e.bin, e.cnt, e.cyc);
                        end
                    end
                    hs_rel = rel;
                    lastb  = int'(out_bin);
                end else if (out_valid && sbq.size() > 0) begin
                    total++;
                    if (out_bin !== sbq[0].bin || out_count !== sbq[0].cnt || mem_addr !== sbq[0].bin || mem_wren !== 1'b0) begin
                        bad++;
                        $display("FAIL stall_hold actual bin=%0d cnt=%0d addr=%0d wren=%b required bin=%0d cnt=%0d addr=%0d wren=0",
                                 out_bin, out_count, mem_addr, mem_wren, sbq[0].bin, sbq[0].cnt, sbq[0].bin);
                    end
                end
                if (mem_wren) begin
                    wren_cnt++;
                    total++;
                    if (int'(mem_addr) != lastb || mem_wdata !== 7'd0 || rel != hs_rel + 1) begin
                        bad++;
                        $display("FAIL clear_write actual addr=%0d data=%0d rel=%0d required addr=%0d data=0 rel=%0d",
                                 mem_addr, mem_wdata, rel, lastb, hs_rel + 1);
                    end
                end
                if (done) begin
                    done_cnt++;
                    if (done_cnt == 1) done_rel = rel;
                end
                exp_busy = (done_rel < 0) || (rel <= done_rel);
                total++;
                if (busy !== exp_busy) begin
                    bad++;
                    $display("FAIL busy rel=%0d actual=%b required=%b", rel, busy, exp_busy);
                end
                if (done_rel >= 0 && rel == done_rel + 1) fin = 1'b1;
                if (!fin && rel >= limit) begin
                    total++; bad++;
                    $display("FAIL timeout rel=%0d actual=no done required=done", rel);
                    fin = 1'b1;
                end
            end
            @(posedge CLK);
            #1;
            rel++;
        end
        RST       = 1'b1;
        out_ready = 1'b1;
        start     = 1'b0;
    endtask

    task automatic check_end(input string name, input int exp_done, input int exp_wren);
        logic [6:0] pb;
        logic [6:0] pc;
        model_peak(pb, pc);
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL %s_missing_words actual=%0d required=0", name, sbq.size());
        end
        total++;
        if (done_cnt != 1 || done_rel != exp_done) begin
            bad++;
            $display("FAIL %s_done actual count=%0d cyc=%0d required count=1 cyc=%0d", name, done_cnt, done_rel, exp_done);
        end
        total++;
        if (wren_cnt != exp_wren) begin
            bad++;
            $display("FAIL %s_wren_count actual=%0d required=%0d", name, wren_cnt, exp_wren);
        end
        repeat (3) @(posedge CLK);
        #1;
        total++;
        if (peak_bin !== pb || peak_count !== pc) begin
            bad++;
            $display("FAIL %s_peak actual bin=%0d cnt=%0d required bin=%0d cnt=%0d", name, peak_bin, peak_count, pb, pc);
        end
    endtask

    task automatic check_ram(input string name);
        int errs;
        errs = 0;
        for (int i = 0; i < 128; i++) if (ram[i] !== img[i]) errs++;
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL %s_ram actual=%0d differing bins required=0", name, errs);
        end
    endtask

    task automatic test_reset();
        RST              = 1'b0;
        start            = 1'b1;
        clear_after_read = 1'b1;
        out_ready        = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        total++;
        if ({out_valid, busy, mem_wren, done, out_bin, out_count, peak_bin, peak_count, mem_addr} !== '0) begin
            bad++;
            $display("FAIL reset_values valid=%b busy=%b wren=%b done=%b bin=%0d cnt=%0d pb=%0d pc=%0d addr=%0d required all zero",
                     out_valid, busy, mem_wren, done, out_bin, out_count, peak_bin, peak_count, mem_addr);
        end
        @(posedge CLK);
        #1;
        RST   = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        total++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle actual busy=%b valid=%b required busy=0 valid=0", busy, out_valid);
        end
    endtask

    task automatic test_plain();
        int t0;
        for (int i = 0; i < 128; i++) img[i] = 7'(i);
        load_ram();
        push_exp(3, 999, 0);
        begin_sweep(1'b0, t0);
        sweep(t0, 0, 0, 0, 0, 1000);
        check_end("plain", 385, 0);
        check_ram("plain");
    endtask

    task automatic test_backpressure();
        int t0;
        for (int i = 0; i < 128; i++) img[i] = 7'(i);
        load_ram();
        push_exp(3, 10, 5);
        begin_sweep(1'b0, t0);
        sweep(t0, 33, 5, 0, 0, 1000);
        check_end("stall", 390, 0);
    endtask

    task automatic test_clear();
        int t0;
        for (int i = 0; i < 128; i++) img[i] = 7'(i);
        load_ram();
        push_exp(4, 999, 0);
        begin_sweep(1'b1, t0);
        sweep(t0, 0, 0, 0, 0, 1000);
        check_end("clear", 513, 128);
        for (int i = 0; i < 128; i++) img[i] = '0;
        check_ram("clear");
        push_exp(3, 999, 0);
        begin_sweep(1'b0, t0);
        sweep(t0, 0, 0, 0, 0, 1000);
        check_end("clear_second", 385, 0);
    endtask

    task automatic test_peak_tie();
        int t0;
        for (int i = 0; i < 128; i++) img[i] = 7'(i % 40);
        img[5] = 7'd42;
        img[9] = 7'd42;
        load_ram();
        push_exp(3, 999, 0);
        begin_sweep(1'b0, t0);
        sweep(t0, 0, 0, 0, 0, 1000);
        check_end("tie", 385, 0);
        total++;
        if (peak_bin !== 7'd5 || peak_count !== 7'd42) begin
            bad++;
            $display("FAIL tie_lowest actual bin=%0d cnt=%0d required bin=5 cnt=42", peak_bin, peak_count);
        end
    endtask

    task automatic test_reset_abort();
        int t0;
        for (int i = 0; i < 128; i++) img[i] = 7'(i);
        load_ram();
        push_exp(4, 999, 0);
        begin_sweep(1'b1, t0);
        sweep(t0, 0, 0, 83, 0, 1000);
        sbq.delete();
        total++;
        if (wren_cnt != 20) begin
            bad++;
            $display("FAIL abort_wren_count actual=%0d required=20", wren_cnt);
        end
        for (int i = 0; i < 20; i++) img[i] = '0;
        repeat (2) @(posedge CLK);
        check_ram("abort");
        push_exp(3, 999, 0);
        begin_sweep(1'b0, t0);
        sweep(t0, 0, 0, 0, 0, 1000);
        check_end("after_abort", 385, 0);
    endtask

    task automatic test_start_ignored();
        int t0;
        for (int i = 0; i < 128; i++) img[i] = 7'(127 - i);
        load_ram();
        push_exp(3, 999, 0);
        begin_sweep(1'b0, t0);
        sweep(t0, 0, 0, 0, 50, 1000);
        check_end("restart", 385, 0);
        check_ram("restart");
    endtask

    initial begin
        test_reset();
        test_plain();
        test_backpressure();
        test_clear();
        test_peak_tie();
        test_reset_abort();
        test_start_ignored();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
